// File: rtl/uart_pkg.sv
// Shared UART definitions: frame FSM states, parity sense and default widths.
// The receive path imports the same parity constants.
`timescale 1ns/1ps
package uart_pkg;

    localparam int UART_WIDTH = 8;
    localparam int PRESCALE_W = 6;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Parity bit for a byte; even sense makes the total count of ones even.
    function automatic logic uart_parity(input logic [UART_WIDTH-1:0] data, input logic par_typ);
        return (^data) ^ par_typ;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: counts 0..period-1 while enabled and flags the last cycle of each bit.
// load_i restarts the count at zero so a new frame always begins on a bit boundary.
`timescale 1ns/1ps
module uart_bit_timer
    import uart_pkg::*;
#(
    parameter int W = PRESCALE_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic         en_i,
    input  logic [W-1:0] period_i,
    output logic         bit_done_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;
    logic         wrap;

    assign wrap       = (count_q == (period_i - W'(1)));
    assign bit_done_o = en_i && wrap;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = wrap ? '0 : count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, LSB-first data, optional parity, one stop bit, each bit
// held for the prescale latched with the byte. Back-to-back frames chain without an idle gap.
`timescale 1ns/1ps
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int WIDTH = UART_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [WIDTH-1:0]      P_DATA,
    input  logic                  DATA_VALID,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] PRESCALE,
    output logic                  TX_OUT,
    output logic                  BUSY
);

    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    uart_state_e           state_q, state_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic [WIDTH-1:0]      shift_q, shift_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;

    logic bit_done;
    logic can_accept;
    logic accept;

    uart_bit_timer #(
        .W (PRESCALE_W)
    ) u_bit_timer (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .load_i     (accept),
        .en_i       (busy_q),
        .period_i   (prescale_q),
        .bit_done_o (bit_done)
    );

    // A new byte may only be taken when idle or in the final cycle of the stop bit.
    assign can_accept = (state_q == IDLE) || ((state_q == STOP) && bit_done);
    assign accept     = can_accept && DATA_VALID && (PRESCALE != '0);

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        busy_d     = busy_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        par_en_d   = par_en_q;
        par_bit_d  = par_bit_q;
        prescale_d = prescale_q;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
            end
            START: begin
                if (bit_done) begin
                    state_d = DATA;
                    tx_d    = shift_q[0];
                    idx_d   = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (idx_q == IDX_W'(WIDTH - 1)) begin
                        if (par_en_q) begin
                            state_d = PARITY;
                            tx_d    = par_bit_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        shift_d = shift_q >> 1;
                        tx_d    = shift_q[1];
                    end
                end
            end
            PARITY: begin
                if (bit_done) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // Acceptance overrides the stop-to-idle step so chained frames keep BUSY high.
        if (accept) begin
            state_d    = START;
            tx_d       = 1'b0;
            busy_d     = 1'b1;
            shift_d    = P_DATA;
            idx_d      = '0;
            par_en_d   = PAR_EN;
            par_bit_d  = (^P_DATA) ^ PAR_TYP;
            prescale_d = PRESCALE;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q    <= IDLE;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            shift_q    <= '0;
            idx_q      <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            prescale_q <= '0;
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            par_en_q   <= par_en_d;
            par_bit_q  <= par_bit_d;
            prescale_q <= prescale_d;
        end
    end

    assign TX_OUT = tx_q;
    assign BUSY   = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a per-cycle line model built from frame rules,
// a behavioural loopback receiver, and hand-computed frame lengths and parity bits.
`timescale 1ns/1ps
module tb_uart_tx_serializer;
    import uart_pkg::*;

    logic       CLK;
    logic       RST;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [5:0] PRESCALE;
    logic       TX_OUT;
    logic       BUSY;

    int checks;
    int errors;
    int rxFrames;
    bit chkEn;

    logic expQ[$];
    logic lineBits[0:1023];

    uart_tx_serializer #(
        .WIDTH (8)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .PRESCALE   (PRESCALE),
        .TX_OUT     (TX_OUT),
        .BUSY       (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Expected line level for every cycle of a frame, one queue entry per clock.
    function automatic void pushFrame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        for (int b = 0; b < bits.size(); b++)
            for (int c = 0; c < int'(ps); c++)
                expQ.push_back(bits[b]);
    endfunction

    // Model: the queue holds the current and remaining cycles of the frame in flight.
    always @(posedge CLK) begin : model
        bit canAcc;
        if (!RST) begin
            expQ.delete();
        end else begin
            canAcc = (expQ.size() <= 1);
            if (expQ.size() > 0) void'(expQ.pop_front());
            if (canAcc && DATA_VALID && PRESCALE != 6'd0)
                pushFrame(P_DATA, PAR_EN, PAR_TYP, PRESCALE);
        end
    end

    always @(negedge CLK) begin : compare
        logic expTx;
        if (chkEn) begin
            expTx = (expQ.size() != 0) ? expQ[0] : 1'b1;
            checkOutput("modelTx", TX_OUT, expTx);
            checkOutput("modelBusy", BUSY, expQ.size() != 0);
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // Called at a negedge; after it returns, cycle 0 of the accepted frame is current.
    task automatic pulseValid(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        P_DATA     = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        PRESCALE   = ps;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        P_DATA     = ~d;
        PAR_TYP    = ~pt;
        PRESCALE   = 6'd5;
    endtask

    task automatic applyStimulus(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
        @(negedge CLK);
        pulseValid(d, pe, pt, ps);
    endtask

    task automatic captureFrame(output int len);
        len = 0;
        while (BUSY === 1'b1 && len < 1024) begin
            lineBits[len] = TX_OUT;
            len++;
            @(negedge CLK);
        end
        checkOutput("frameEndBusy", BUSY, 1'b0);
    endtask

    // Sends one byte and decodes the captured line at mid-bit like a receiver would.
    task automatic runFrame(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps,
                            input int expLen, input logic expPar);
        int len;
        int p;
        logic [7:0] rxData;
        logic startB, parB, stopB, parErr, stpErr;
        p = int'(ps);
        applyStimulus(d, pe, pt, ps);
        captureFrame(len);
        checkOutput("frameLen", 16'(len), 16'(expLen));
        startB = lineBits[p / 2];
        for (int i = 0; i < 8; i++) rxData[i] = lineBits[(1 + i) * p + p / 2];
        parB   = pe ? lineBits[9 * p + p / 2] : 1'b0;
        stopB  = lineBits[(9 + int'(pe)) * p + p / 2];
        parErr = pe && (parB != ((^rxData) ^ pt));
        stpErr = (stopB != 1'b1);
        checkOutput("rxStart", startB, 1'b0);
        checkOutput("rxData", rxData, d);
        checkOutput("rxParErr", parErr, 1'b0);
        checkOutput("rxStpErr", stpErr, 1'b0);
        if (pe) checkOutput("rxParityBit", parB, expPar);
        if (startB == 1'b0 && stopB == 1'b1) rxFrames++;
    endtask

    initial begin : watchdog
        #1000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        checks     = 0;
        errors     = 0;
        rxFrames   = 0;
        chkEn      = 1'b0;
        RST        = 1'b0;
        P_DATA     = 8'h00;
        DATA_VALID = 1'b0;
        PAR_EN     = 1'b0;
        PAR_TYP    = PAR_EVEN;
        PRESCALE   = 6'd8;
        waitCycles(3);
        checkOutput("resetTx", TX_OUT, 1'b1);
        checkOutput("resetBusy", BUSY, 1'b0);
        RST   = 1'b1;
        chkEn = 1'b1;
        waitCycles(2);

        runFrame(8'hAA, 1'b1, PAR_EVEN, 6'd8,  88,  1'b0);
        runFrame(8'hEA, 1'b1, PAR_ODD,  6'd16, 176, 1'b0);
        runFrame(8'h55, 1'b0, PAR_EVEN, 6'd32, 320, 1'b0);
        runFrame(8'h3C, 1'b1, PAR_EVEN, 6'd16, 176, 1'b0);
        runFrame(8'h81, 1'b1, PAR_ODD,  6'd8,  88,  1'b1);
        runFrame(8'h01, 1'b1, PAR_EVEN, 6'd32, 352, 1'b1);

        // Busy handling: mid-frame request dropped, last-stop request chained.
        begin
            int len;
            applyStimulus(8'hAA, 1'b1, PAR_EVEN, 6'd8);
            waitCycles(19);
            pulseValid(8'h12, 1'b0, PAR_EVEN, 6'd8);
            checkOutput("ignoreTx", TX_OUT, 1'b1);
            checkOutput("ignoreBusy", BUSY, 1'b1);
            waitCycles(67);
            pulseValid(8'h3C, 1'b0, PAR_EVEN, 6'd8);
            checkOutput("chainTx", TX_OUT, 1'b0);
            checkOutput("chainBusy", BUSY, 1'b1);
            captureFrame(len);
            checkOutput("chainLen", 16'(len), 16'd80);
            waitCycles(5);
            checkOutput("afterChainBusy", BUSY, 1'b0);
        end

        // Reset in the middle of data bit 3 abandons the frame.
        applyStimulus(8'hAA, 1'b1, PAR_EVEN, 6'd8);
        waitCycles(33);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("midResetTx", TX_OUT, 1'b1);
        checkOutput("midResetBusy", BUSY, 1'b0);
        RST = 1'b1;
        waitCycles(2);
        runFrame(8'hAA, 1'b1, PAR_EVEN, 6'd8, 88, 1'b0);

        // Zero prescale never starts a frame.
        @(negedge CLK);
        P_DATA     = 8'hAA;
        PRESCALE   = 6'd0;
        DATA_VALID = 1'b1;
        @(negedge CLK);
        DATA_VALID = 1'b0;
        checkOutput("ps0Busy", BUSY, 1'b0);
        waitCycles(10);
        checkOutput("ps0Tx", TX_OUT, 1'b1);

        checkOutput("rxFrameCount", 16'(rxFrames), 16'd7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
